// File: rtl/cla_test_pkg.sv
// Shared types and constants for the CLA exhaustive self-test block.
package cla_test_pkg;

    localparam int unsigned VEC_W = 9;
    localparam int unsigned ERR_W = 10;
    localparam int unsigned RES_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    // Reference result {Cout,Sum} for vector {Cin,A,B}.
    function automatic logic [RES_W-1:0] exp_result(input logic [VEC_W-1:0] v);
        return {1'b0, v[7:4]} + {1'b0, v[3:0]} + {4'b0000, v[8]};
    endfunction

endpackage

// File: rtl/cla_self_test_if.sv
// Bus between the self-test controller and the CLA under test / status observer.
interface cla_self_test_if;
    import cla_test_pkg::*;

    logic             start;
    logic [3:0]       sum;
    logic             cout;
    logic [3:0]       a;
    logic [3:0]       b;
    logic             cin;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] first_fail_vec;
    logic             first_fail_valid;

    modport master (
        input  start, sum, cout,
        output a, b, cin, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, sum, cout,
        input  a, b, cin, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

endinterface

// File: rtl/cla_exp_pipe.sv
// LAT-deep delay line carrying the expected result, its vector index and a valid tag.
module cla_exp_pipe
    import cla_test_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [VEC_W-1:0] vec_i,
    input  logic [RES_W-1:0] exp_i,
    output logic             valid_o,
    output logic [VEC_W-1:0] vec_o,
    output logic [RES_W-1:0] exp_o
);

    logic [LAT-1:0]   valid_q;
    logic [VEC_W-1:0] vec_q [LAT];
    logic [RES_W-1:0] exp_q [LAT];

    // Shift register; flush drops every in-flight entry including the incoming one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                vec_q[i] <= '0;
                exp_q[i] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q[0] <= valid_i;
            vec_q[0]   <= vec_i;
            exp_q[0]   <= exp_i;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                vec_q[i]   <= vec_q[i-1];
                exp_q[i]   <= exp_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LAT-1];
    assign vec_o   = vec_q[LAT-1];
    assign exp_o   = exp_q[LAT-1];

endmodule

// File: rtl/cla_self_test.sv
// Exhaustive self-test of a 4-bit registered CLA: drives all 512 {Cin,A,B} vectors,
// checks the returned {Cout,Sum} after LAT cycles and records error statistics.
module cla_self_test
    import cla_test_pkg::*;
#(
    parameter int unsigned LAT          = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_self_test_if.master bus
);

    localparam logic [VEC_W-1:0] LastVec = '1;
    localparam logic [1:0]       DrainLast = 2'(LAT - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [1:0]       drain_q, drain_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [VEC_W-1:0] ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;
    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    logic             flush;
    logic             pipe_valid;
    logic [VEC_W-1:0] pipe_vec;
    logic [RES_W-1:0] pipe_exp;
    logic             mismatch;

    // Reset asserts asynchronously, releases two clock edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    cla_exp_pipe #(
        .LAT (LAT)
    ) u_exp_pipe (
        .clk     (clk),
        .rst_n   (rst_int_n),
        .flush_i (flush),
        .valid_i (state_q == StRun),
        .vec_i   (vec_q),
        .exp_i   (exp_result(vec_q)),
        .valid_o (pipe_valid),
        .vec_o   (pipe_vec),
        .exp_o   (pipe_exp)
    );

    assign mismatch = pipe_valid && ({bus.cout, bus.sum} != pipe_exp);

    // State, vector counter and result registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            drain_q   <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    // Next-state: checker first, then FSM so an accepted Start clears the results.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        drain_d   = drain_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        flush     = 1'b0;

        if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!ffvalid_q) begin
                ffv_d     = pipe_vec;
                ffvalid_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d   = StRun;
                    vec_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            StRun: begin
                if (vec_q == LastVec) begin
                    state_d = StDrain;
                    vec_d   = '0;
                    drain_d = '0;
                end else begin
                    vec_d = vec_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (STOP_ON_FAIL && mismatch) begin
            state_d = StDone;
            vec_d   = '0;
            flush   = 1'b1;
        end
    end

    assign bus.cin              = vec_q[8];
    assign bus.a                = vec_q[7:4];
    assign bus.b                = vec_q[3:0];
    assign bus.busy             = (state_q == StRun) || (state_q == StDrain);
    assign bus.done             = (state_q == StDone);
    assign bus.pass             = (state_q == StDone) && (err_q == '0);
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: doc/cla_self_test.md
CLA_SELF_TEST -- requirements
Module: cla_self_test

Interface
REQ-001 Parameter LAT, default 1, is the DUT result latency in clock cycles (legal range 1..4).
REQ-002 Parameter STOP_ON_FAIL, default 0; when 1, the run ends at the first mismatch.
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request for an exhaustive run; sampled only in IDLE or DONE.
REQ-006 Sum_in  input  4  registered CLA sum returned by the DUT.
REQ-007 Cout_in  input  1  registered CLA carry-out returned by the DUT.
REQ-008 A  output  4  operand A driven to the DUT; registered.
REQ-009 B  output  4  operand B driven to the DUT; registered.
REQ-010 Cin  output  1  carry-in driven to the DUT; registered.
REQ-011 Busy  output  1  high in RUN and DRAIN.
REQ-012 Done  output  1  high in DONE.
REQ-013 Pass  output  1  equals Done AND (Err_count == 0).
REQ-014 Err_count  output  10  number of mismatching vectors in the current run.
REQ-015 First_fail_vec  output  9  {Cin,A,B} of the first mismatching vector.
REQ-016 First_fail_valid  output  1  high once First_fail_vec holds a captured value.

Function
REQ-017 Vector index v is 9 bits; {Cin,A,B} = v, with B in the LSBs; the sequence is v = 0..511, ascending, with no wrap-around.
REQ-018 FSM states and transitions:
- IDLE -> RUN on Start.
- RUN -> DRAIN after vector 511 is driven.
- DRAIN -> DONE after LAT cycles.
- DONE -> RUN on Start.
- No other transitions.
REQ-019 Start while in RUN or DRAIN is ignored.
REQ-020 On a Start accepted from IDLE or DONE, the block SHALL:
- drive vector 0 in the next cycle;
- clear Err_count, First_fail_vec and First_fail_valid in that same cycle.
REQ-021 In RUN, one new vector is driven per cycle, with no stalls.
REQ-022 Expected result = A + B + Cin as a 5-bit value {Cout,Sum}, computed from the registered drive outputs and delayed LAT cycles by a valid-tagged pipeline.
REQ-023 The response to vector k is compared at the edge ending cycle k+LAT, counting from vector 0's cycle.
REQ-024 Compare rules: compare only when the pipeline valid tag is set; a mismatch on either Sum_in or Cout_in counts once per vector.
REQ-025 On a mismatch while First_fail_valid = 0, capture v into First_fail_vec and set First_fail_valid.
REQ-026 Err_count increments by 1 per mismatch; its maximum is 512, so it never overflows.
REQ-027 With STOP_ON_FAIL = 1, the first mismatch moves the FSM directly to DONE; in-flight pipeline entries are discarded.
REQ-028 In IDLE, DRAIN and DONE, A, B and Cin hold the value 0.
REQ-029 With STOP_ON_FAIL = 0, Done rises in cycle 513+LAT after the Start edge.
REQ-030 Done, Pass and the result registers hold their values until the next accepted Start or until reset.

Reset
REQ-031 Reset_n low asynchronously forces:
- the FSM to IDLE;
- A, B, Cin, Busy, Done, Pass, Err_count, First_fail_vec and First_fail_valid to 0;
- all pipeline valid tags to 0.
REQ-032 Reset mid-run aborts the run; no partial results are retained.
REQ-033 Reset release is synchronised to Clk.

Structure
REQ-034 Shared package cla_test_pkg SHALL hold:
- the FSM state enum (IDLE, RUN, DRAIN, DONE);
- the constants VEC_W = 9 and ERR_W = 10.
REQ-035 Sub-module cla_exp_pipe SHALL implement the LAT-deep expected-result/valid delay line.
REQ-036 The top level SHALL hold the FSM, vector counter and checker.

Verification
REQ-037 Fault-free registered CLA model, LAT = 1 -> Done high in cycle 514, Err_count = 0, Pass = 1, First_fail_valid = 0.
REQ-038 Sum_in[0] stuck at 0 -> Err_count = 256, First_fail_vec = 9'h001, Pass = 0.
REQ-039 Cout_in stuck at 0 -> Err_count = 256, First_fail_vec = 9'h01F.
REQ-040 STOP_ON_FAIL = 1 with Sum_in[0] stuck at 0 -> DONE entered after the compare of vector 1, Err_count = 1.
REQ-041 Reset_n pulsed low while v = 100 -> all outputs 0 immediately, FSM in IDLE; a subsequent Start gives a clean run (Pass = 1).
REQ-042 LAT = 3 with a 3-cycle DUT model, plus Start pulsed during RUN -> Start ignored, Done in cycle 516, Pass = 1.
